// File: rtl/danger_scroller_if.sv
// Control and status bundle between the game sequencer and the danger obstacle scroller.
// The master drives the game-step strobes; the slave (the scroller) returns the obstacle state.
interface danger_scroller_if;
  logic        tick;
  logic        start;
  logic        crash;
  logic [8:0]  pos;
  logic        spawn;
  logic [15:0] pass_cnt;
  logic [3:0]  speed;
  logic        running;

  modport master (
    output tick, start, crash,
    input  pos, spawn, pass_cnt, speed, running
  );

  modport slave (
    input  tick, start, crash,
    output pos, spawn, pass_cnt, speed, running
  );
endinterface

// File: rtl/danger_scroller.sv
// Obstacle motion controller: scrolls the danger sprite left, counts passes and respawns it after an LFSR gap.
// Optional speed ramp every eighth pass is enabled by defining DANGER_SPEEDUP_EN.
module danger_scroller #(
  parameter int unsigned SPAWN_X   = 346,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned MAX_SPEED = 6,
  parameter int unsigned GAP_MIN   = 20,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input logic               clk,
  input logic               rst,
  danger_scroller_if.slave  bus
);

`ifdef DANGER_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  localparam logic [8:0] SPAWN_POS  = 9'(SPAWN_X);
  localparam logic [3:0] BASE_SPEED = 4'(SPEED);
  localparam logic [3:0] TOP_SPEED  = 4'(MAX_SPEED);
  localparam logic [6:0] GAP_BASE   = 7'(GAP_MIN);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    GAP,
    HALT
  } state_t;

  state_t      state;
  logic [8:0]  pos_q;
  logic        spawn_q;
  logic [15:0] pass_cnt_q;
  logic [3:0]  speed_q;
  logic        running_q;
  logic [7:0]  lfsr;
  logic [6:0]  gap_cnt;

  logic [7:0]  lfsr_next;
  logic        pass_sat;
  logic [15:0] pass_inc;
  logic [3:0]  speed_after_pass;

  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign pass_sat  = (pass_cnt_q == 16'hFFFF);
  assign pass_inc  = pass_sat ? pass_cnt_q : pass_cnt_q + 16'd1;

  // Ramp only on a real increment landing on a multiple of eight; folds to a plain hold when disabled.
  assign speed_after_pass = (SPEEDUP && !pass_sat && (pass_inc[2:0] == 3'd0) && (speed_q < TOP_SPEED))
                            ? speed_q + 4'd1 : speed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pos_q      <= 9'd0;
      spawn_q    <= 1'b0;
      pass_cnt_q <= 16'd0;
      speed_q    <= BASE_SPEED;
      running_q  <= 1'b0;
      lfsr       <= LFSR_SEED;
      gap_cnt    <= 7'd0;
    end else begin
      spawn_q <= 1'b0;
      if (bus.crash) begin
        if (state == MOVE || state == GAP) begin
          state     <= HALT;
          running_q <= 1'b0;
        end
      end else if (bus.start) begin
        if (state == IDLE || state == HALT) begin
          state      <= MOVE;
          pos_q      <= SPAWN_POS;
          spawn_q    <= 1'b1;
          pass_cnt_q <= 16'd0;
          speed_q    <= BASE_SPEED;
          running_q  <= 1'b1;
        end
      end else if (bus.tick && running_q) begin
        lfsr <= lfsr_next;
        if (state == MOVE) begin
          // Compare before subtracting so the 9-bit position never wraps.
          if (pos_q > {5'd0, speed_q}) begin
            pos_q <= pos_q - {5'd0, speed_q};
          end else begin
            pos_q      <= 9'd0;
            pass_cnt_q <= pass_inc;
            speed_q    <= speed_after_pass;
            gap_cnt    <= GAP_BASE + {1'b0, lfsr[5:0]};
            state      <= GAP;
          end
        end else if (state == GAP) begin
          if (gap_cnt == 7'd0) begin
            state   <= MOVE;
            pos_q   <= SPAWN_POS;
            spawn_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 7'd1;
          end
        end
      end
    end
  end

  assign bus.pos      = pos_q;
  assign bus.spawn    = spawn_q;
  assign bus.pass_cnt = pass_cnt_q;
  assign bus.speed    = speed_q;
  assign bus.running  = running_q;

endmodule

// File: tb/tb_danger_scroller.sv
// Scoreboard bench for danger_scroller: a behavioural model queues expected outputs per driven cycle.
// Directed checks cover reset, transit length, gap length, crash hold, speed ramp and pass saturation.
module tb_danger_scroller;
  localparam int unsigned SPAWN_X   = 346;
  localparam int unsigned SPEED     = 2;
  localparam int unsigned MAX_SPEED = 6;
  localparam int unsigned GAP_MIN   = 20;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  danger_scroller_if bus ();

  danger_scroller #(
    .SPAWN_X   (SPAWN_X),
    .SPEED     (SPEED),
    .MAX_SPEED (MAX_SPEED),
    .GAP_MIN   (GAP_MIN),
    .LFSR_SEED (LFSR_SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  pos;
    logic        spawn;
    logic [15:0] pass_cnt;
    logic [3:0]  speed;
    logic        running;
  } out_t;

  typedef enum logic [1:0] {M_IDLE, M_MOVE, M_GAP, M_HALT} mstate_t;

  out_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  mstate_t     m_state;
  logic [8:0]  m_pos;
  logic        m_spawn;
  logic [15:0] m_pass;
  logic [3:0]  m_speed;
  logic        m_running;
  logic [7:0]  m_lfsr;
  logic [6:0]  m_gap;

  function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic model_reset();
    m_state   = M_IDLE;
    m_pos     = 9'd0;
    m_spawn   = 1'b0;
    m_pass    = 16'd0;
    m_speed   = 4'(SPEED);
    m_running = 1'b0;
    m_lfsr    = LFSR_SEED;
    m_gap     = 7'd0;
  endtask

  task automatic model_step(input logic t, input logic s, input logic c);
    out_t e;
    m_spawn = 1'b0;
    if (c) begin
      if (m_state == M_MOVE || m_state == M_GAP) begin
        m_state   = M_HALT;
        m_running = 1'b0;
      end
    end else if (s) begin
      if (m_state == M_IDLE || m_state == M_HALT) begin
        m_state   = M_MOVE;
        m_pos     = 9'(SPAWN_X);
        m_spawn   = 1'b1;
        m_pass    = 16'd0;
        m_speed   = 4'(SPEED);
        m_running = 1'b1;
      end
    end else if (t && m_running) begin
      if (m_state == M_MOVE) begin
        if (int'(m_pos) > int'(m_speed)) begin
          m_pos = 9'(int'(m_pos) - int'(m_speed));
        end else begin
          m_pos = 9'd0;
          if (m_pass != 16'hFFFF) begin
            m_pass = m_pass + 16'd1;
`ifdef DANGER_SPEEDUP_EN
            if (m_pass % 8 == 0 && int'(m_speed) < int'(MAX_SPEED)) m_speed = m_speed + 4'd1;
`endif
          end
          m_gap   = 7'(GAP_MIN + int'(m_lfsr % 64));
          m_state = M_GAP;
        end
      end else begin
        if (m_gap == 7'd0) begin
          m_state = M_MOVE;
          m_pos   = 9'(SPAWN_X);
          m_spawn = 1'b1;
        end else begin
          m_gap = m_gap - 7'd1;
        end
      end
      m_lfsr = lfsr_adv(m_lfsr);
    end
    e.pos      = m_pos;
    e.spawn    = m_spawn;
    e.pass_cnt = m_pass;
    e.speed    = m_speed;
    e.running  = m_running;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic t, input logic s, input logic c);
    out_t e;
    @(negedge clk);
    bus.tick  = t;
    bus.start = s;
    bus.crash = c;
    model_step(t, s, c);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checkOutput("pos", 32'(bus.pos), 32'(e.pos));
    checkOutput("spawn", 32'(bus.spawn), 32'(e.spawn));
    checkOutput("pass_cnt", 32'(bus.pass_cnt), 32'(e.pass_cnt));
    checkOutput("speed", 32'(bus.speed), 32'(e.speed));
    checkOutput("running", 32'(bus.running), 32'(e.running));
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.crash = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_to_passes(input logic [15:0] target);
    int budget;
    budget = 20000;
    while (m_pass < target && budget > 0) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      budget--;
    end
    checkOutput("pass_reached", 32'(bus.pass_cnt), 32'(target));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] ref_lfsr;
    int         gap_ticks;
    int         exp_gap;

    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.crash = 1'b0;
    model_reset();

    // Reset held while tick toggles: outputs must stay at their reset values.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.tick = ~bus.tick;
    end
    #1;
    checkOutput("rst_pos", 32'(bus.pos), 32'd0);
    checkOutput("rst_running", 32'(bus.running), 32'd0);
    checkOutput("rst_pass_cnt", 32'(bus.pass_cnt), 32'd0);
    checkOutput("rst_speed", 32'(bus.speed), 32'd2);
    @(negedge clk);
    rst      = 1'b0;
    bus.tick = 1'b0;
    run_ticks(3);
    checkOutput("idle_tick_pos", 32'(bus.pos), 32'd0);

    // Full transit from spawn to pass.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("start_spawn", 32'(bus.spawn), 32'd1);
    checkOutput("start_pos", 32'(bus.pos), 32'd346);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("spawn_one_cycle", 32'(bus.spawn), 32'd0);
    run_ticks(172);
    checkOutput("pos_after_172", 32'(bus.pos), 32'd2);
    run_ticks(1);
    checkOutput("pass_pos", 32'(bus.pos), 32'd0);
    checkOutput("pass_cnt_1", 32'(bus.pass_cnt), 32'd1);
    checkOutput("gap_running", 32'(bus.running), 32'd1);

    // Respawn delay against an independent LFSR walk from the seed.
    ref_lfsr = LFSR_SEED;
    for (int i = 0; i < 172; i++) ref_lfsr = lfsr_adv(ref_lfsr);
    exp_gap   = int'(GAP_MIN) + int'(ref_lfsr[5:0]) + 1;
    gap_ticks = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      gap_ticks++;
      if (bus.spawn) break;
    end
    checkOutput("gap_ticks", 32'(gap_ticks), 32'(exp_gap));
    checkOutput("respawn_pos", 32'(bus.pos), 32'd346);

    // Crash with a concurrent tick at pos=100 freezes everything.
    run_ticks(123);
    checkOutput("pre_crash_pos", 32'(bus.pos), 32'd100);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("halt_pos", 32'(bus.pos), 32'd100);
    checkOutput("halt_running", 32'(bus.running), 32'd0);
    checkOutput("halt_pass_cnt", 32'(bus.pass_cnt), 32'd1);
    run_ticks(3);
    checkOutput("halt_tick_ignored", 32'(bus.pos), 32'd100);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("restart_pos", 32'(bus.pos), 32'd346);
    checkOutput("restart_pass_cnt", 32'(bus.pass_cnt), 32'd0);
    run_ticks(5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("start_in_move_ignored", 32'(bus.pos), 32'd336);

    // Speed ramp (or constant speed when the ramp is compiled out).
    run_to_passes(16'd8);
`ifdef DANGER_SPEEDUP_EN
    checkOutput("speed_at_8", 32'(bus.speed), 32'd3);
`else
    checkOutput("speed_at_8", 32'(bus.speed), 32'd2);
`endif
    run_to_passes(16'd32);
`ifdef DANGER_SPEEDUP_EN
    checkOutput("speed_at_32", 32'(bus.speed), 32'd6);
`else
    checkOutput("speed_at_32", 32'(bus.speed), 32'd2);
`endif
    run_to_passes(16'd41);
`ifdef DANGER_SPEEDUP_EN
    checkOutput("speed_capped", 32'(bus.speed), 32'd6);
`else
    checkOutput("speed_capped", 32'(bus.speed), 32'd2);
`endif

    // Asynchronous reset mid-run overrides a concurrent tick.
    run_ticks(2);
    @(negedge clk);
    bus.tick = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_pos", 32'(bus.pos), 32'd0);
    checkOutput("async_rst_running", 32'(bus.running), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_over_tick_pos", 32'(bus.pos), 32'd0);
    checkOutput("rst_pass_clear", 32'(bus.pass_cnt), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    bus.tick = 1'b0;
    model_reset();

    // Pass counter saturation.
    applyStimulus(1'b0, 1'b1, 1'b0);
    run_ticks(3);
    @(negedge clk);
    force dut.pass_cnt_q = 16'hFFFF;
    #1;
    release dut.pass_cnt_q;
    m_pass = 16'hFFFF;
    checkOutput("sat_forced", 32'(bus.pass_cnt), 32'hFFFF);
    for (int i = 0; i < 400; i++) begin
      if (m_state == M_GAP) break;
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkOutput("sat_gap_state", 32'(bus.pos), 32'd0);
    checkOutput("sat_hold", 32'(bus.pass_cnt), 32'hFFFF);
    checkOutput("sat_speed", 32'(bus.speed), 32'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/danger_scroller.md
# danger_scroller

Obstacle motion controller for the dino game. Produces the 9-bit right-edge x position (half-resolution, 0–511) consumed by the danger sprite renderer. Each game tick it moves the obstacle left, counts passes, and after a pseudo-random gap respawns the obstacle off the right edge. Position 0 means "nothing drawn", because the renderer's visible window is empty at 0.

## Interface
Parameters:
- SPAWN_X, 346: respawn position, i.e. 320 + 26 sprite width, fully off-screen.
- SPEED, 2: initial pixels moved per tick (1–15).
- MAX_SPEED, 6: speed ceiling, used only with the speedup feature.
- GAP_MIN, 20: minimum ticks between a pass and the next respawn.
- LFSR_SEED, 8'hA5: LFSR reset value; must be non-zero.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- tick, in, 1: single-cycle game-step enable, synchronous to clk.
- start, in, 1: single-cycle pulse that begins or restarts a run.
- crash, in, 1: collision; a level or a pulse is accepted.
- pos, out, 9: obstacle right-edge x, routed to the renderer `pos` input.
- spawn, out, 1: one-cycle pulse issued when the obstacle is placed at SPAWN_X.
- pass_cnt, out, 16: obstacles passed, saturating.
- speed, out, 4: current step size.
- running, out, 1: high in the MOVE and GAP states.

## Operation
- States:
  - IDLE: reset state. pos=0.
  - MOVE: obstacle travelling.
  - GAP: obstacle absent, counting down to respawn.
  - HALT: frozen after a crash.
- IDLE, start → MOVE:
  - pos=SPAWN_X, spawn=1.
  - pass_cnt=0, speed=SPEED.
- MOVE, tick:
  - If pos > speed: pos = pos − speed.
  - Otherwise: pos=0, pass_cnt+1 (saturating at 16'hFFFF), gap_cnt = GAP_MIN + lfsr[5:0], go to GAP.
- GAP, tick:
  - If gap_cnt==0: go to MOVE, pos=SPAWN_X, spawn=1.
  - Otherwise: gap_cnt−1.
- MOVE or GAP, crash → HALT. pos, pass_cnt and speed hold their values.
- HALT, start → MOVE. Same actions as IDLE→start, so the counters restart.
- start while in MOVE or GAP is ignored.
- tick while in IDLE or HALT is ignored.
- Priority within a single cycle: rst > crash > start > tick.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances on every tick while running=1, including the tick that loads gap_cnt.
  - gap_cnt is loaded from the pre-advance value.
- Width rules:
  - gap_cnt is 7 bits; the maximum load is GAP_MIN+63.
  - pos arithmetic is 9-bit unsigned and never underflows, because of the compare-before-subtract.

## Timing
- All outputs are registered. The effect of a tick, start or crash sampled at edge N is visible after edge N.
- spawn is high for exactly one clk cycle per placement.
- Reset values: pos=0, spawn=0, pass_cnt=0, speed=SPEED, running=0, state IDLE, lfsr=LFSR_SEED, gap_cnt=0.
- rst asserted mid-run forces the reset values immediately (asynchronously) and overrides any concurrent tick.
- Transit length: one obstacle takes ceil(SPAWN_X/speed) ticks from spawn to pass.
- Respawn delay: after the pass, respawn follows gap_cnt+1 ticks later.

## Configuration
- Macro: DANGER_SPEEDUP_EN.
- Defined:
  - Each time pass_cnt increments to a value whose [2:0]==0, speed = min(speed+1, MAX_SPEED).
  - The new speed applies from the next tick.
- Undefined:
  - speed is constant at SPEED.
  - MAX_SPEED is unused.

## Test plan
- Reset:
  - Stimulus: assert rst with tick toggling.
  - Required: pos=0, running=0, pass_cnt=0, speed=2. After release, tick alone leaves pos at 0.
- Transit:
  - Stimulus: start, then 172 ticks.
  - Required: spawn one cycle, pos=346 after start. pos=2 after 172 ticks. Tick 173 gives pos=0, pass_cnt=1, state GAP.
- Gap:
  - Stimulus: after the first pass with the default seed, compare gap_cnt against a reference LFSR model.
  - Required: respawn (spawn=1, pos=346) occurs exactly GAP_MIN + lfsr[5:0] + 1 ticks after the pass.
- Crash:
  - Stimulus: crash and tick in the same cycle while pos=100.
  - Required: HALT, pos stays 100, running=0. A later start gives pos=346, pass_cnt=0.
- Speedup (with DANGER_SPEEDUP_EN):
  - Stimulus: run for 8 passes, then for 32 passes.
  - Required: speed=3 once pass_cnt=8. speed=6 at pass_cnt=32 and stays 6 afterwards.
  - Without the macro, speed stays 2.
- Saturation:
  - Stimulus: force pass_cnt=16'hFFFF, complete one more pass.
  - Required: pass_cnt stays 16'hFFFF.
